led_display_arbiter: RTL and testbench
======================================

// Module: led_display_arbiter
// PURPOSE
//   Shares the 8-bit LED display among N_REQ pattern generators (e.g. sequencer FSMs).
//   Round-robin arbitration with a guaranteed minimum ownership time measured in display ticks.
//   Owns the shared prescaler and broadcasts its tick so requesters step their patterns in lockstep.
//   Sits between the pattern generators and the board LED pins.
// PARAMETERS
//   N_REQ         4           number of requesters (2..8)
//   TICK_DIV      50000000    clk cycles per display tick (>=2)
//   HOLD_TICKS    4           minimum ticks an owner keeps the display before it can be preempted (>=1)
//   IDLE_PATTERN  8'h00       led_out value when no requester owns the display
// PORTS
//   clk         in   1          system clock, rising edge
//   reset       in   1          asynchronous, active-high; clears all state immediately
//   req         in   N_REQ      req[i]=1: requester i wants the display
//   pattern_in  in   8*N_REQ    requester i pattern on bits [8i+7:8i]
//   grant       out  N_REQ      one-hot owner, all-zero when idle (registered)
//   led_out     out  8          display drive (registered)
//   tick        out  1          one-clk pulse every TICK_DIV clks (registered)
//   busy        out  1          1 while any requester owns the display
// BEHAVIOUR
// - Reset values: grant=0, led_out=IDLE_PATTERN, tick=0, busy=0, prescaler=0, hold_cnt=0, last_owner=N_REQ-1.
// - Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the one clk after count==TICK_DIV-1, so period = TICK_DIV clks.
//   Free-running; never affected by arbitration.
// - FSM, two states:
//   IDLE: grant=0. If any req is high, at the next edge grant the winner and go to OWN with hold_cnt=0.
//   OWN:  hold_cnt increments on each tick and saturates at HOLD_TICKS. Transitions are evaluated every clk, in this priority:
//     1. Owner req low -> release. If another req is high, grant the RR winner directly (stay OWN, hold_cnt=0); otherwise go to IDLE.
//     2. hold_cnt==HOLD_TICKS and another req is high -> switch to the RR winner (hold_cnt=0).
//     3. Otherwise keep the owner. With no competitor, ownership continues indefinitely past the hold.
// - Round-robin: search starts at (last_owner+1) mod N_REQ, wraps, and picks the first req set.
//   The current owner is excluded in case 2. last_owner updates on every grant.
//   After reset, req0 wins ties.
// - Latency:
//   - req rising in IDLE at edge k -> grant and led_out valid after edge k+1.
//   - Release and regrant -> no idle cycle between owners.
// - led_out <= pattern_in slice of the next-cycle owner, or IDLE_PATTERN if none. The live pattern is tracked every clk,
//   so led_out changes in the same cycle as grant and lags pattern_in by 1 clk.
// - A tick and a release on the same clk: the release wins; the new owner starts at hold_cnt=0 (that tick is not counted).
// - grant is always one-hot or zero; busy = |grant.
// - Reset asserted mid-ownership drops grant and led_out to reset values asynchronously, with no glitch-through of the old pattern.
// TESTING (bench with TICK_DIV=4, HOLD_TICKS=2, N_REQ=4)
// 1. After reset, no req for 20 clks -> grant=0, led_out=8'h00, tick high exactly on every 4th clk.
// 2. req=4'b0101 simultaneously in IDLE, patterns 8'hAA/8'h55 -> grant=0001, led_out=AA next clk;
//    after 2 ticks, grant=0100, led_out=55.
// 3. Only req1 high for 10 ticks -> grant stays 0010 throughout; changing pattern_in[15:8] to 8'h81 appears on led_out 1 clk later.
// 4. req0 owns; req2 rises; req0 drops after 1 tick -> grant=0100 on the next clk (early release, no idle cycle).
// 5. All four req held high -> grant rotates 0001, 0010, 0100, 1000, 0001, each owner held exactly 2 ticks.
// 6. Async reset pulse mid-ownership, between clk edges -> grant=0, led_out=00 immediately;
//    after release, req3 alone -> grant=1000.

Source files
------------

// File: rtl/led_display_arbiter.sv
// Round-robin owner of the shared 8-bit LED display with a minimum hold in display ticks.
// Also owns the free-running prescaler whose tick all pattern generators step on.
module led_display_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned HOLD_TICKS   = 4,
    parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   pattern_in,
    output logic [N_REQ-1:0]     grant,
    output logic [7:0]           led_out,
    output logic                 tick,
    output logic                 busy
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    prescaler;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [IDX_W-1:0]    last_owner, last_n;
    logic [N_REQ-1:0]    grant_n;
    logic [7:0]          led_n;
    logic [N_REQ-1:0]    cand;
    logic                take;
    logic [IDX_W-1:0]    win;

    // Free-running prescaler; tick is the registered wrap strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= (prescaler == CNT_W'(TICK_DIV - 1));
            if (prescaler == CNT_W'(TICK_DIV - 1))
                prescaler <= '0;
            else
                prescaler <= prescaler + CNT_W'(1);
        end
    end

    // Round-robin pick among cand, starting just after last_owner.
    always_comb begin
        logic            found;
        int unsigned     idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = 32'(last_owner) + i;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (!found && cand[IDX_W'(idx)]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    // While owning, last_owner is the current owner's index.
    always_comb begin
        state_n = state;
        grant_n = grant;
        hold_n  = hold_cnt;
        last_n  = last_owner;
        cand    = '0;
        take    = 1'b0;
        led_n   = IDLE_PATTERN;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    cand = req;
                    take = 1'b1;
                end
            end
            S_OWN: begin
                if (!req[last_owner]) begin
                    if (|req) begin
                        cand = req;
                        take = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        grant_n = '0;
                    end
                end else if (hold_cnt == HOLD_W'(HOLD_TICKS) && |(req & ~grant)) begin
                    cand = req & ~grant;
                    take = 1'b1;
                end else if (tick && hold_cnt != HOLD_W'(HOLD_TICKS)) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (take) begin
            state_n      = S_OWN;
            grant_n      = '0;
            grant_n[win] = 1'b1;
            hold_n       = '0;
            last_n       = win;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_n[IDX_W'(i)])
                led_n = pattern_in[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= '0;
            led_out    <= IDLE_PATTERN;
            busy       <= 1'b0;
            hold_cnt   <= '0;
            last_owner <= IDX_W'(N_REQ - 1);
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            led_out    <= led_n;
            busy       <= |grant_n;
            hold_cnt   <= hold_n;
            last_owner <= last_n;
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Scoreboard bench for led_display_arbiter: driver pushes model predictions, monitor pops and compares.
module tb_led_display_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int HT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [8*N-1:0] pattern_in;
    logic [N-1:0]  grant;
    logic [7:0]    led_out;
    logic          tick;
    logic          busy;

    led_display_arbiter #(
        .N_REQ(N), .TICK_DIV(TD), .HOLD_TICKS(HT), .IDLE_PATTERN(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .pattern_in(pattern_in),
        .grant(grant), .led_out(led_out), .tick(tick), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] g;
        logic [7:0]   l;
        logic         t;
        logic         b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: owner index (-1 = none), ticks held, last granted, edges since reset.
    int m_owner, m_hold, m_last, m_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int last, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_last  = N - 1;
        m_n     = 0;
    endtask

    // Advance the model across one rising edge using the current inputs, push the prediction.
    task automatic apply();
        bit   tick_cur;
        int   w;
        exp_t e;
        tick_cur = (m_n > 0) && (m_n % TD == 0);
        if (m_owner < 0) begin
            w = rr(req, m_last, -1);
            if (w >= 0) begin m_owner = w; m_hold = 0; m_last = w; end
        end else if (!req[m_owner]) begin
            w = rr(req, m_last, -1);
            m_owner = w;
            if (w >= 0) begin m_hold = 0; m_last = w; end
        end else if (m_hold == HT && rr(req, m_last, m_owner) >= 0) begin
            w = rr(req, m_last, m_owner);
            m_owner = w; m_hold = 0; m_last = w;
        end else if (tick_cur && m_hold < HT) begin
            m_hold++;
        end
        m_n++;
        e.g = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.l = (m_owner >= 0) ? pattern_in[8*m_owner +: 8] : 8'h00;
        e.t = (m_n % TD == 0);
        e.b = (m_owner >= 0);
        q.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [8*N-1:0] p);
        @(negedge clk);
        req        = r;
        pattern_in = p;
        apply();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_led",   32'(led_out), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_tick",  32'(tick), 32'h0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        model_reset();
        apply();
        mon_en = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual=empty required=entry at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("grant",   32'(grant),   32'(e.g));
                check("led_out", 32'(led_out), 32'(e.l));
                check("tick",    32'(tick),    32'(e.t));
                check("busy",    32'(busy),    32'(e.b));
            end
        end
    end

    function automatic logic [8*N-1:0] rand_pat();
        return {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    initial begin
        logic [8*N-1:0] p;
        logic [N-1:0]   r;
        reset      = 1'b0;
        req        = '0;
        pattern_in = '0;
        #1;
        do_reset();

        // Idle with ticks every fourth clock.
        for (int i = 0; i < 20; i++) drive('0, rand_pat());

        // Simultaneous req0/req2, fixed patterns.
        p = {8'h00, 8'h55, 8'h00, 8'hAA};
        for (int i = 0; i < 30; i++) drive(4'b0101, p);
        for (int i = 0; i < 3; i++)  drive('0, p);

        // Lone req1 with a changing pattern, including 8'h81.
        for (int i = 0; i < 40; i++) begin
            p = rand_pat();
            if (i == 17) p[15:8] = 8'h81;
            drive(4'b0010, p);
        end
        for (int i = 0; i < 3; i++) drive('0, p);

        // req0 owns, req2 joins, req0 drops early.
        p = rand_pat();
        for (int i = 0; i < 3; i++) drive(4'b0001, p);
        for (int i = 0; i < 5; i++) drive(4'b0101, p);
        for (int i = 0; i < 12; i++) drive(4'b0100, p);

        // All requesters: full rotation.
        for (int i = 0; i < 50; i++) drive(4'b1111, rand_pat());

        // Async reset between edges mid-ownership, then req3 alone.
        @(posedge clk);
        #3;
        do_reset();
        for (int i = 0; i < 10; i++) drive(4'b1000, rand_pat());

        // Random traffic with sticky requests.
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
            drive(r, rand_pat());
            if (i == 300) begin
                @(posedge clk);
                #4;
                do_reset();
            end
        end

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
